// File: rtl/gen_chk_tx.sv
// gen_chk_tx: stimulus generator for the TX datapath plus a dual-path checker
// that compares the behavioural and synthesised TX output streams beat by beat.
module gen_chk_tx #(
    parameter int          DATA_W    = 32,
    parameter int          OUT_W     = 8,
    parameter int          NUM_WORDS = 16,
    parameter int          CNT_W     = 16,
    parameter int          DRAIN_CYC = 8,
    parameter logic [31:0] SEED      = 32'hACE1ACE1
) (
    input  logic              i_clk_2f,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_pattern,
    input  logic [3:0]        i_gap,
    input  logic [OUT_W-1:0]  i_data_out_a,
    input  logic              i_valid_out_a,
    input  logic [OUT_W-1:0]  i_data_out_b,
    input  logic              i_valid_out_b,
    output logic              o_active,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data_input,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [CNT_W-1:0]  o_err_count,
    output logic [CNT_W-1:0]  o_first_err_idx
);

    localparam int DRN_W = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {IDLE, SEND, GAP, DRAIN, DONE} StateT;

    StateT             r_state;
    StateT             w_nextState;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_pattern;
    logic [3:0]        r_gap;
    logic [CNT_W-1:0]  r_idx;
    logic [3:0]        r_gapCnt;
    logic [DRN_W-1:0]  r_drainCnt;
    logic [31:0]       r_lfsr;
    logic [DATA_W-1:0] r_walk;
    logic              r_active;
    logic              r_valid;
    logic [DATA_W-1:0] r_dataInput;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [CNT_W-1:0]  r_errCount;
    logic [CNT_W-1:0]  r_firstErrIdx;
    logic [CNT_W-1:0]  r_beatIdx;

    logic              w_startAccept;
    logic              w_lastWord;
    logic              w_gapEnd;
    logic              w_drainEnd;
    logic [31:0]       w_seed;
    logic [31:0]       w_lfsrNext;
    logic [DATA_W-1:0] w_lfsrWord;
    logic [DATA_W-1:0] w_word;
    logic              w_beat;
    logic              w_mismatch;

    // A new run is only taken once the previous one has fully settled, so the
    // cycle where the FSM has just reached DONE but busy is still high is excluded.
    assign w_startAccept = i_start && !r_busy && ((r_state == IDLE) || (r_state == DONE));
    assign w_lastWord    = (r_idx == CNT_W'(NUM_WORDS - 1));
    assign w_gapEnd      = (r_gapCnt == (r_gap - 4'd1));
    assign w_drainEnd    = (r_drainCnt == DRN_W'(DRAIN_CYC - 1));

    // A zero seed would lock the LFSR, so a zero pattern selects the default seed.
    assign w_seed     = (32'(i_pattern) == 32'd0) ? SEED : 32'(i_pattern);
    assign w_lfsrNext = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
    assign w_lfsrWord = DATA_W'(r_lfsr);

    assign w_beat     = r_busy && (i_valid_out_a || i_valid_out_b);
    assign w_mismatch = (i_valid_out_a != i_valid_out_b) ||
                        (i_valid_out_a && i_valid_out_b && (i_data_out_a != i_data_out_b));

    // Select the word for the current index from the mode latched at start.
    always_comb begin
        w_word = r_pattern;
        case (r_mode)
            2'b00:   w_word = r_pattern + DATA_W'(r_idx);
            2'b01:   w_word = w_lfsrWord;
            2'b10:   w_word = r_pattern;
            default: w_word = r_walk;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk_2f) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode: one SEND per word, optional GAP stretch, then DRAIN.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_startAccept) begin
                    w_nextState = SEND;
                end
            end
            SEND: begin
                if (w_lastWord) begin
                    w_nextState = DRAIN;
                end else if (r_gap != 4'd0) begin
                    w_nextState = GAP;
                end else begin
                    w_nextState = SEND;
                end
            end
            GAP: begin
                if (w_gapEnd) begin
                    w_nextState = SEND;
                end
            end
            DRAIN: begin
                if (w_drainEnd) begin
                    w_nextState = DONE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Run configuration, word index, gap/drain timers and pattern generators.
    always_ff @(posedge i_clk_2f) begin
        if (i_reset) begin
            r_mode     <= 2'b00;
            r_pattern  <= '0;
            r_gap      <= 4'd0;
            r_idx      <= '0;
            r_gapCnt   <= 4'd0;
            r_drainCnt <= '0;
            r_lfsr     <= SEED;
            r_walk     <= DATA_W'(1);
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_startAccept) begin
                        r_mode     <= i_mode;
                        r_pattern  <= i_pattern;
                        r_gap      <= i_gap;
                        r_idx      <= '0;
                        r_gapCnt   <= 4'd0;
                        r_drainCnt <= '0;
                        r_lfsr     <= w_seed;
                        r_walk     <= DATA_W'(1);
                    end
                end
                SEND: begin
                    r_lfsr   <= w_lfsrNext;
                    r_walk   <= {r_walk[DATA_W-2:0], r_walk[DATA_W-1]};
                    r_gapCnt <= 4'd0;
                    if (!w_lastWord) begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end
                GAP: begin
                    r_gapCnt <= r_gapCnt + 4'd1;
                end
                DRAIN: begin
                    r_drainCnt <= r_drainCnt + DRN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Registered stimulus and status outputs, one cycle behind the FSM state.
    always_ff @(posedge i_clk_2f) begin
        if (i_reset) begin
            r_active    <= 1'b0;
            r_valid     <= 1'b0;
            r_dataInput <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                SEND: begin
                    r_active    <= 1'b1;
                    r_valid     <= 1'b1;
                    r_dataInput <= w_word;
                    r_busy      <= 1'b1;
                    r_done      <= 1'b0;
                end
                GAP: begin
                    r_active <= 1'b1;
                    r_valid  <= 1'b0;
                    r_busy   <= 1'b1;
                    r_done   <= 1'b0;
                end
                DRAIN: begin
                    r_active    <= 1'b0;
                    r_valid     <= 1'b0;
                    r_dataInput <= '0;
                    r_busy      <= 1'b1;
                    r_done      <= 1'b0;
                end
                DONE: begin
                    r_active    <= 1'b0;
                    r_valid     <= 1'b0;
                    r_dataInput <= '0;
                    r_busy      <= 1'b0;
                    r_done      <= !w_startAccept;
                end
                default: begin
                    r_active    <= 1'b0;
                    r_valid     <= 1'b0;
                    r_dataInput <= '0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    // Beat checker: counts at most one mismatch per beat, saturating, and
    // remembers the beat index of the first one.
    always_ff @(posedge i_clk_2f) begin
        if (i_reset) begin
            r_error       <= 1'b0;
            r_errCount    <= '0;
            r_firstErrIdx <= '0;
            r_beatIdx     <= '0;
        end else if (w_startAccept) begin
            r_error       <= 1'b0;
            r_errCount    <= '0;
            r_firstErrIdx <= '0;
            r_beatIdx     <= '0;
        end else if (w_beat) begin
            r_beatIdx <= r_beatIdx + CNT_W'(1);
            if (w_mismatch) begin
                r_error <= 1'b1;
                if (r_errCount != '1) begin
                    r_errCount <= r_errCount + CNT_W'(1);
                end
                if (!r_error) begin
                    r_firstErrIdx <= r_beatIdx;
                end
            end
        end
    end

    assign o_active        = r_active;
    assign o_valid         = r_valid;
    assign o_data_input    = r_dataInput;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_error         = r_error;
    assign o_err_count     = r_errCount;
    assign o_first_err_idx = r_firstErrIdx;

endmodule
